// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame layout and command codes
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ESPERA, DONE, ERR} estado_t;
  localparam int BITS_TRAMA  = 11;
  localparam int IDX_PARIDAD = 9;
  localparam int IDX_STOP    = 10;
  localparam logic [7:0] CMD_LEDS   = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] RESP_ACK   = 8'hFA;
endpackage

// File: rtl/ps2_clk_filtro.sv
// ps2_clk_filtro: synchronises ps2_clk/ps2_dat, deglitches ps2_clk and flags its falling edges
module ps2_clk_filtro #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_f_o,
  output logic dat_s_o,
  output logic caida_o
);
  localparam int CW = $clog2(FILT_LEN > 1 ? FILT_LEN : 2);
  logic [1:0] clk_s, dat_s;
  logic [CW-1:0] cnt;
  logic cambia;
  // cnt tracks how many consecutive samples disagree with the filtered level
  assign cambia  = (clk_s[1] != clk_f_o) && (cnt == CW'(FILT_LEN - 1));
  assign dat_s_o = dat_s[1];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      clk_s   <= 2'b11;
      dat_s   <= 2'b11;
      cnt     <= '0;
      clk_f_o <= 1'b1;
      caida_o <= 1'b0;
    end else begin
      clk_s   <= {clk_s[0], ps2_clk_i};
      dat_s   <= {dat_s[0], ps2_dat_i};
      cnt     <= (clk_s[1] == clk_f_o || cambia) ? '0 : cnt + 1'b1;
      clk_f_o <= cambia ? clk_s[1] : clk_f_o;
      caida_o <= cambia & clk_f_o;
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device via request-to-send and checks the ack
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] dato_i,
  input  logic       iniciar_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  output logic       ocupado_o,
  output logic       listo_o,
  output logic       error_o
);
  localparam int IW = $clog2(INHIBIT_CYC > 1 ? INHIBIT_CYC : 2);
  localparam int TW = $clog2(TIMEOUT_CYC > 1 ? TIMEOUT_CYC : 2);
  estado_t st, st_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0] n, n_n;
  logic [BITS_TRAMA-1:0] sh, sh_n;
  logic clk_f, dat_s, caida, vence;
  logic clk_oe_n, dat_oe_n, ocup_n, listo_n, err_n;

  ps2_clk_filtro #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ps2_clk_i(ps2_clk_i),
    .ps2_dat_i(ps2_dat_i),
    .clk_f_o  (clk_f),
    .dat_s_o  (dat_s),
    .caida_o  (caida)
  );

  assign vence = tcnt == TW'(TIMEOUT_CYC - 1);

  // sh holds the whole frame {stop, parity, data, start}; bit 0 is the one on the line
  always_comb begin
    st_n   = st;
    icnt_n = '0;
    tcnt_n = '0;
    n_n    = n;
    sh_n   = sh;
    case (st)
      IDLE: if (iniciar_i) begin
        st_n = INHIBIT;
        sh_n = {1'b1, ~^dato_i, dato_i, 1'b0};
        n_n  = '0;
      end
      INHIBIT: begin
        icnt_n = icnt + 1'b1;
        if (icnt == IW'(INHIBIT_CYC - 1)) begin
          st_n   = RTS;
          icnt_n = '0;
        end
      end
      RTS: st_n = SEND;
      SEND: begin
        tcnt_n = tcnt + 1'b1;
        if (caida && n == 4'(IDX_STOP)) st_n = dat_s ? ERR : ESPERA;
        else if (caida) begin
          n_n  = n + 1'b1;
          sh_n = {1'b1, sh[BITS_TRAMA-1:1]};
        end
        if (vence) st_n = ERR;
      end
      ESPERA: begin
        tcnt_n = tcnt + 1'b1;
        st_n   = vence ? ERR : (clk_f && dat_s) ? DONE : ESPERA;
      end
      default: st_n = IDLE;
    endcase
    clk_oe_n = st_n inside {INHIBIT, RTS};
    dat_oe_n = (st_n inside {RTS, SEND}) && !sh_n[0];
    ocup_n   = st_n inside {INHIBIT, RTS, SEND, ESPERA};
    listo_n  = st_n == DONE;
    err_n    = st_n == ERR;
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      st           <= IDLE;
      icnt         <= '0;
      tcnt         <= '0;
      n            <= '0;
      sh           <= '1;
      ps2_clk_oe_o <= 1'b0;
      ps2_dat_oe_o <= 1'b0;
      ocupado_o    <= 1'b0;
      listo_o      <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      st           <= st_n;
      icnt         <= icnt_n;
      tcnt         <= tcnt_n;
      n            <= n_n;
      sh           <= sh_n;
      ps2_clk_oe_o <= clk_oe_n;
      ps2_dat_oe_o <= dat_oe_n;
      ocupado_o    <= ocup_n;
      listo_o      <= listo_n;
      error_o      <= err_n;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model clocks frames out of the host and checks them against the byte
module tb_ps2_host_tx;
  localparam int INH = 20, TMO = 2000, FL = 4, HALF = 30;
  localparam int M_ACK = 0, M_NACK = 1, M_TMO = 2, M_RST = 3;

  logic clk_i = 0, rst_i = 0, iniciar_i = 0;
  logic [7:0] dato_i = '0;
  logic dev_clk = 0, dev_dat = 0, glitch = 0;
  logic ps2_clk_i, ps2_dat_i, ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o, listo_o, error_o;
  int n_cmp = 0, n_err = 0, n_listo = 0, n_error = 0;
  bit both = 0;

  assign ps2_clk_i = ~(ps2_clk_oe_o | dev_clk | glitch);
  assign ps2_dat_i = ~(ps2_dat_oe_o | dev_dat);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILT_LEN(FL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dato_i(dato_i), .iniciar_i(iniciar_i),
    .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe_o(ps2_clk_oe_o), .ps2_dat_oe_o(ps2_dat_oe_o),
    .ocupado_o(ocupado_o), .listo_o(listo_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (listo_o) n_listo++;
    if (error_o) n_error++;
    if (listo_o && error_o) both = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] b, input int mode, input bit gl, input bit busy);
    logic [10:0] cap;
    int n, l0, e0;
    l0 = n_listo;
    e0 = n_error;
    cap = '0;
    dato_i = b;
    iniciar_i = 1;
    @(negedge clk_i);
    iniciar_i = 0;
    dato_i = 8'($urandom);
    n = 0;
    while (ps2_clk_oe_o && !ps2_dat_oe_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk("inhibit_len", n, INH);
    chk("rts_lines", {ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o}, 3'b111);
    @(negedge clk_i);
    chk("send_start", {ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o}, 3'b011);
    if (mode == M_TMO) begin
      n = 0;
      while (!error_o && n < 3000) begin
        @(negedge clk_i);
        n++;
      end
      chk("timeout_cyc", n, TMO);
      chk("timeout_lines", {ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o, listo_o, error_o}, 5'b00001);
      repeat (2) @(negedge clk_i);
      chk("timeout_listo_cnt", n_listo - l0, 0);
      chk("timeout_err_cnt", n_error - e0, 1);
      return;
    end
    cap[0] = ps2_dat_i;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && mode == M_ACK) dev_dat = 1;
      for (int c = 0; c < HALF; c++) begin
        glitch = gl && k == 4 && (c == 15 || c == 16);
        iniciar_i = busy && k == 3 && c == 10;
        if (iniciar_i) dato_i = ~b;
        @(negedge clk_i);
      end
      glitch = 0;
      iniciar_i = 0;
      dev_clk = 1;
      repeat (HALF) @(negedge clk_i);
      dev_clk = 0;
      if (k <= 10) cap[k] = ps2_dat_i;
      if (mode == M_RST && k == 5) begin
        #1 rst_i = 0;
        #1 chk("rst_async", {ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o, listo_o, error_o}, 0);
        dev_dat = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_hold", {ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o}, 0);
        rst_i = 1;
        repeat (2) @(negedge clk_i);
        return;
      end
    end
    dev_dat = 0;
    n = 0;
    while (ocupado_o && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    chk("ocupado_drop", ocupado_o, 0);
    repeat (2) @(negedge clk_i);
    chk("frame_bits", cap, frame_of(b));
    chk("end_lines", {ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o}, 0);
    chk("listo_cnt", n_listo - l0, mode == M_ACK ? 1 : 0);
    chk("err_cnt", n_error - e0, mode == M_NACK ? 1 : 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o, listo_o, error_o}, 0);
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    chk("idle_outputs", {ps2_clk_oe_o, ps2_dat_oe_o, ocupado_o, listo_o, error_o}, 0);
    send(8'hED, M_ACK, 0, 0);
    send(8'h00, M_ACK, 0, 0);
    send(8'hF4, M_NACK, 0, 0);
    send(8'hED, M_TMO, 0, 0);
    send(8'hED, M_ACK, 1, 0);
    send(8'hED, M_RST, 0, 0);
    send(8'hFF, M_ACK, 0, 1);
    for (int i = 0; i < 4; i++) send(8'($urandom), M_ACK, 1'($urandom_range(0, 1)), 0);
    chk("listo_error_exclusive", both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
